sr_btn_ctrl: RTL

Upstream command stage for sr_ff. Converts two raw, bouncy pushbuttons into clean single-cycle set/reset commands in the 2-bit s/r encoding that sr_ff consumes: 2'b01 means asserted, 2'b00 means idle. Each button is synchronised, debounced and edge-detected, and simultaneous presses are arbitrated. The block also reports conflicts and keeps a count of issued commands for display on the lab board.

---
 rtl/sr_btn_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/sr_btn_ctrl.sv
// sr_btn_ctrl: turns two raw, bouncy pushbuttons into clean single-cycle
// set/reset commands for sr_ff. The set and reset channels each get their own
// synchronizer, debouncer and rising-edge detector. Simultaneous presses are
// arbitrated with reset taking priority, and every issued command is counted.
module sr_btn_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_set,
  input  logic             btn_rst,
  input  logic             en,
  output logic [1:0]       s,
  output logic [1:0]       r,
  output logic             conflict,
  output logic [CNT_W-1:0] cmd_count
);

  // Debounce counter width: ceil(log2(DEBOUNCE_CYCLES)), never less than 1 bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is the set button and channel 1 is the reset button.
  logic [1:0]                  btn_raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  sync_lvl;
  logic [1:0][CW-1:0]          dbcnt_q, dbcnt_d;
  logic [1:0]                  db_q, db_d;
  logic [1:0]                  db_dly_q;
  logic [1:0]                  press;

  logic [1:0]       s_q, s_d;
  logic [1:0]       r_q, r_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign btn_raw = {btn_rst, btn_set};

  // Shift each raw button into its synchronizer chain; the top bit is the synchronized level.
  always_comb begin
    sync_d   = sync_q;
    sync_lvl = '0;
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch]   = {sync_q[ch][SYNC_STAGES-2:0], btn_raw[ch]};
      sync_lvl[ch] = sync_q[ch][SYNC_STAGES-1];
    end
  end

  // The stable level follows the synchronized level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_d    = db_q;
    dbcnt_d = dbcnt_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync_lvl[ch] == db_q[ch]) begin
        dbcnt_d[ch] = '0;
      end else if (dbcnt_q[ch] == DB_LAST) begin
        db_d[ch]    = sync_lvl[ch];
        dbcnt_d[ch] = '0;
      end else begin
        dbcnt_d[ch] = dbcnt_q[ch] + CW'(1);
      end
    end
  end

  // A press is a rising edge of the debounced level; releases are ignored.
  assign press = db_q & ~db_dly_q;

  // Build the command for the output register; reset wins when both buttons are pressed at once, as sr_ff does.
  always_comb begin
    s_d        = 2'b00;
    r_d        = 2'b00;
    conflict_d = 1'b0;
    count_d    = count_q;
    if (en) begin
      if (press[1]) begin
        r_d        = 2'b01;
        conflict_d = press[0];
      end else if (press[0]) begin
        s_d = 2'b01;
      end
      if (|press) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // All state registers; an asynchronous reset clears every one of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      dbcnt_q    <= '0;
      db_q       <= '0;
      db_dly_q   <= '0;
      s_q        <= 2'b00;
      r_q        <= 2'b00;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      dbcnt_q    <= dbcnt_d;
      db_q       <= db_d;
      db_dly_q   <= db_q;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign conflict  = conflict_q;
  assign cmd_count = count_q;

endmodule
